// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache for a single-issue pipeline.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   cpu_re, cpu_we        load / store request (both high = store)
//   cpu_mode              funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   cpu_addr, cpu_wdata   byte address and store data
//   cpu_rdata             extended load data, valid in the cycle stall is low
//   stall                 pipeline freeze while missing or transferring
//   mem_req/we/addr/wdata registered backing-memory beat request
//   mem_rdata, mem_ack    backing-memory response; a beat completes when req && ack
//   hit_count, miss_count statistics, only when DCACHE_STATS_EN is defined (else tied to 0)
//
// Address split: [1:0] byte, [3:2] word, [3+log2(SETS):4] index, rest tag.
module data_cache #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SETS  = 64,
  parameter int unsigned WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [2:0]       cpu_mode,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned WordW = $clog2(WORDS);
  localparam int unsigned TagW  = WIDTH - 2 - WordW - IdxW;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e             state_q, state_d;
  logic [WordW-1:0]   beat_q, beat_d, beat_nxt;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [WIDTH-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  logic [WIDTH-1:0]   data_q [SETS][WORDS];
  logic [TagW-1:0]    tag_q  [SETS];
  logic [SETS-1:0]    valid_q, dirty_q;

  logic [1:0]         byte_off;
  logic [WordW-1:0]   word_off;
  logic [IdxW-1:0]    idx;
  logic [TagW-1:0]    tag;
  logic               req, hit, idle_req, store_hit, fire, last_beat, fill_done;
  logic [WIDTH-1:0]   cur_word, store_word, load_ext;
  logic [7:0]         ld_b;
  logic [15:0]        ld_h;

  assign byte_off  = cpu_addr[1:0];
  assign word_off  = cpu_addr[2 +: WordW];
  assign idx       = cpu_addr[2 + WordW +: IdxW];
  assign tag       = cpu_addr[WIDTH-1 -: TagW];
  assign req       = cpu_re | cpu_we;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign idle_req  = (state_q == StIdle) && req;
  assign store_hit = idle_req && cpu_we && hit;
  // mem_ack outside an active request never advances anything
  assign fire      = mem_req_q & mem_ack;
  assign last_beat = (beat_q == WordW'(WORDS - 1));
  assign beat_nxt  = beat_q + WordW'(1);
  assign cur_word  = data_q[idx][word_off];

  // Store merge: H ignores addr[0], W ignores addr[1:0].
  always_comb begin
    store_word = cur_word;
    case (cpu_mode[1:0])
      2'b00:   store_word[{byte_off, 3'b000} +: 8]     = cpu_wdata[7:0];
      2'b01:   store_word[{byte_off[1], 4'b0000} +: 16] = cpu_wdata[15:0];
      default: store_word = cpu_wdata;
    endcase
  end

  // Load extraction and extension.
  always_comb begin
    ld_b = cur_word[{byte_off, 3'b000} +: 8];
    ld_h = cur_word[{byte_off[1], 4'b0000} +: 16];
    case (cpu_mode)
      3'b000:  load_ext = {{(WIDTH-8){ld_b[7]}}, ld_b};
      3'b001:  load_ext = {{(WIDTH-16){ld_h[15]}}, ld_h};
      3'b100:  load_ext = {{(WIDTH-8){1'b0}}, ld_b};
      3'b101:  load_ext = {{(WIDTH-16){1'b0}}, ld_h};
      default: load_ext = cur_word;
    endcase
  end

  assign stall     = !rst && ((state_q != StIdle) || (req && !hit));
  assign cpu_rdata = (!rst && cpu_re && !cpu_we && (state_q == StIdle) && hit) ? load_ext : '0;

  // Memory-side outputs are registered, so the first beat is set up on the miss edge.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && !hit) begin
          beat_d    = '0;
          mem_req_d = 1'b1;
          if (dirty_q[idx]) begin
            state_d     = StWriteback;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[idx], idx, {WordW{1'b0}}, 2'b00};
            mem_wdata_d = data_q[idx][0];
          end else begin
            state_d    = StAllocate;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, idx, {WordW{1'b0}}, 2'b00};
          end
        end
      end
      StWriteback: begin
        if (fire) begin
          if (last_beat) begin
            // mem_req stays high straight into the refill
            state_d    = StAllocate;
            beat_d     = '0;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, idx, {WordW{1'b0}}, 2'b00};
          end else begin
            beat_d      = beat_nxt;
            mem_addr_d  = {tag_q[idx], idx, beat_nxt, 2'b00};
            mem_wdata_d = data_q[idx][beat_nxt];
          end
        end
      end
      StAllocate: begin
        if (fire) begin
          if (last_beat) begin
            state_d   = StIdle;
            beat_d    = '0;
            mem_req_d = 1'b0;
            fill_done = 1'b1;
          end else begin
            beat_d     = beat_nxt;
            mem_addr_d = {tag, idx, beat_nxt, 2'b00};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (store_hit) dirty_q[idx] <= 1'b1;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Data and tag arrays carry no reset; valid_q gates them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (store_hit) data_q[idx][word_off] <= store_word;
      if ((state_q == StAllocate) && fire) data_q[idx][beat_q] <= mem_rdata;
      if (fill_done) tag_q[idx] <= tag;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  // Set after a refill so the retry hit is not counted as a new access.
  logic        refilled_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refilled_q <= 1'b0;
    end else begin
      if (fill_done)     refilled_q <= 1'b1;
      else if (idle_req) refilled_q <= 1'b0;
      if (idle_req && hit && !refilled_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (idle_req && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_mode = 3'b010;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        stall, mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [31:0] hit_count, miss_count;

  data_cache dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_mode  (cpu_mode),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } beat_t;

  int          n_checks = 0, n_fail = 0;
  logic [31:0] bmem    [1024];
  logic [31:0] ref_mem [1024];
  logic        m_valid [64];
  logic        m_dirty [64];
  logic [21:0] m_tag   [64];
  beat_t       beat_q [$];
  logic [31:0] rd_q [$];
  int          exp_hits = 0, exp_misses = 0;
  int          ack_delay = 0, wait_cnt = 0;
  logic [31:0] held_addr = '0;
  bit          sb_on = 1'b1;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int v);
`ifdef DCACHE_STATS_EN
    return 32'(v);
`else
    return (v >= 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] mode,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (mode)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] mode, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (mode[1:0])
      2'b00:   r[{off, 3'b000} +: 8] = d[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Backing memory: decides mem_ack for the coming edge and checks each completing beat.
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      if (wait_cnt < ack_delay) begin
        mem_ack = 1'b0;
        if (wait_cnt == 0) held_addr = mem_addr;
        else begin
          check_eq("hold_addr", mem_addr, held_addr);
          check_eq("hold_stall", {31'd0, stall}, 32'd1);
        end
        wait_cnt++;
      end else begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) bmem[mem_addr[11:2]] = mem_wdata;
        else        mem_rdata = bmem[mem_addr[11:2]];
        if (sb_on) begin
          if (beat_q.size() == 0) begin
            check_eq("beat_unexpected", mem_addr, 32'hFFFF_FFFF);
          end else begin
            beat_t b;
            b = beat_q.pop_front();
            check_eq("beat_addr", mem_addr, b.addr);
            check_eq("beat_we", {31'd0, mem_we}, {31'd0, b.we});
            if (b.we) check_eq("beat_wdata", mem_wdata, b.data);
          end
        end
      end
    end else begin
      wait_cnt = 0;
      // Spurious ack while idle in zero-wait mode; must be ignored.
      mem_ack  = (ack_delay == 0);
    end
  end

  task automatic access(input logic re, input logic we, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata, input int exp_stall);
    logic [5:0]  idx;
    logic [21:0] t;
    logic        hit;
    logic [31:0] exp_rd;
    int          n;
    beat_t       b;
    idx = addr[9:4];
    t   = addr[31:10];
    hit = m_valid[idx] && (m_tag[idx] == t);
    if (hit) exp_hits++;
    else begin
      exp_misses++;
      if (m_dirty[idx]) begin
        for (int w = 0; w < 4; w++) begin
          b.addr = {m_tag[idx], idx, 2'(w), 2'b00};
          b.we   = 1'b1;
          b.data = ref_mem[b.addr[11:2]];
          beat_q.push_back(b);
        end
      end
      for (int w = 0; w < 4; w++) begin
        b.addr = {t, idx, 2'(w), 2'b00};
        b.we   = 1'b0;
        b.data = '0;
        beat_q.push_back(b);
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = t;
      m_dirty[idx] = 1'b0;
    end
    exp_rd = '0;
    if (we) begin
      ref_mem[addr[11:2]] = store_merge(ref_mem[addr[11:2]], wdata, mode, addr[1:0]);
      m_dirty[idx] = 1'b1;
    end else if (re) begin
      exp_rd = load_ext(ref_mem[addr[11:2]], mode, addr[1:0]);
    end
    rd_q.push_back(exp_rd);

    @(negedge clk);
    cpu_re = re; cpu_we = we; cpu_mode = mode; cpu_addr = addr; cpu_wdata = wdata;
    n = 0;
    #1;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check_eq("stall_cycles", 32'(n), 32'(exp_stall));
    exp_rd = rd_q.pop_front();
    if (!(re && we)) check_eq("rdata", cpu_rdata, exp_rd);
    @(negedge clk);
    cpu_re = 1'b0; cpu_we = 1'b0;
    #1;
    check_eq("beats_left", 32'(beat_q.size()), 32'd0);
    check_eq("hit_count", hit_count, exp_stat(exp_hits));
    check_eq("miss_count", miss_count, exp_stat(exp_misses));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bmem[i]    = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      ref_mem[i] = bmem[i];
    end
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
    end

    // Reset with a load request present: outputs stay quiet.
    rst = 1'b1; cpu_re = 1'b1; cpu_addr = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; cpu_re = 1'b0;
    #1;
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_hits", hit_count, 32'd0);
    check_eq("rst_misses", miss_count, 32'd0);

    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5);          // clean miss
    access(1'b0, 1'b1, 3'b000, 32'h102, 32'h80, 0);         // SB hit
    access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 0);          // LB -> sign
    check_eq("lb_const", ref_mem[32'h100 >> 2][23:16] == 8'h80 ? 32'hFFFF_FF80 : 32'h0,
             32'hFFFF_FF80);
    access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 0);          // LBU
    access(1'b0, 1'b1, 3'b001, 32'h106, 32'h1234_8765, 0);  // SH upper half
    access(1'b1, 1'b0, 3'b001, 32'h106, 32'h0, 0);          // LH
    access(1'b1, 1'b0, 3'b101, 32'h107, 32'h0, 0);          // LHU ignores addr[0]
    access(1'b0, 1'b1, 3'b010, 32'h10B, 32'hDEAD_BEEF, 0);  // SW ignores addr[1:0]
    access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 0);
    access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 9);          // dirty eviction
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5);          // written-back data returns
    access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 0);
    access(1'b1, 1'b1, 3'b010, 32'h104, 32'hCAFE_F00D, 0);  // re+we acts as store
    access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0);
    access(1'b0, 1'b1, 3'b010, 32'h300, 32'h55AA_33CC, 5);  // write-allocate
    access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0);

    // Idle cycles: no stall, no counter movement.
    repeat (3) begin
      @(negedge clk);
      #1;
      check_eq("idle_stall", {31'd0, stall}, 32'd0);
      check_eq("idle_hits", hit_count, exp_stat(exp_hits));
    end

    ack_delay = 3;
    access(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 17);         // slow memory
    ack_delay = 0;

    // Reset during the second refill beat.
    sb_on = 1'b0;
    @(negedge clk);
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_mode = 3'b010; cpu_addr = 32'h9C0;
    #1;
    check_eq("abort_miss_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    #1;
    check_eq("abort_beat0", mem_addr, 32'h9C0);
    @(negedge clk);
    check_eq("abort_beat1", mem_addr, 32'h9C4);
    rst = 1'b1;
    #1;
    check_eq("abort_rst_stall", {31'd0, stall}, 32'd0);
    check_eq("abort_rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; cpu_re = 1'b0;
    #1;
    check_eq("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("abort_stall", {31'd0, stall}, 32'd0);
    check_eq("abort_misses", miss_count, 32'd0);
    beat_q.delete();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = bmem[i];
    exp_hits = 0; exp_misses = 0;
    sb_on = 1'b1;
    access(1'b1, 1'b0, 3'b010, 32'h9C0, 32'h0, 5);          // misses again
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5);          // all lines were invalidated

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
